// File: rtl/chip8_mem_pkg.sv
// Shared types and constants for the CHIP-8 RAM arbiter: owner-state encoding,
// read-return tags and default bus widths.
package chip8_mem_pkg;

  localparam int unsigned DefAddrW = 12;
  localparam int unsigned DefDataW = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCpuLock = 2'd1,
    StPpuLock = 2'd2
  } owner_e;

  typedef logic [1:0] tag_t;

  localparam tag_t TagNone = 2'd0;
  localparam tag_t TagCpu  = 2'd1;
  localparam tag_t TagPpu  = 2'd2;
  localparam tag_t TagVid  = 2'd3;

endpackage

// File: rtl/chip8_arb2.sv
// Two-way CPU/PPU picker with force-CPU override. MEM_ARB_ROUND_ROBIN_EN selects
// pointer-based alternation on conflicts; otherwise PPU wins.
module chip8_arb2 (
  input  logic cpu_req,
  input  logic ppu_req,
  input  logic force_cpu,
  input  logic ptr,
  output logic cpu_gnt,
  output logic ppu_gnt,
  output logic ptr_toggle
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic unused_ptr;
  assign unused_ptr = ptr;
`endif

  always_comb begin
    cpu_gnt    = 1'b0;
    ppu_gnt    = 1'b0;
    ptr_toggle = 1'b0;
    if (cpu_req && (force_cpu || !ppu_req)) begin
      cpu_gnt = 1'b1;
    end else if (ppu_req && !cpu_req) begin
      ppu_gnt = 1'b1;
    end else if (ppu_req && cpu_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      // ptr low favours the PPU; flip after every contested pick
      ptr_toggle = 1'b1;
      cpu_gnt    = ptr;
      ppu_gnt    = ~ptr;
`else
      ppu_gnt = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Arbitrates the CHIP-8 RAM read/write ports between CPU, PPU and video scanout,
// with owner locking and CPU starvation forcing. Option: MEM_ARB_ROUND_ROBIN_EN.
module chip8_mem_arbiter
  import chip8_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd_req,
  input  logic              ppu_rd_req,
  input  logic              vid_rd_req,
  input  logic [ADDR_W-1:0] cpu_rd_addr,
  input  logic [ADDR_W-1:0] ppu_rd_addr,
  input  logic [ADDR_W-1:0] vid_rd_addr,
  output logic              cpu_rd_gnt,
  output logic              ppu_rd_gnt,
  output logic              vid_rd_gnt,
  output logic              cpu_rd_valid,
  output logic              ppu_rd_valid,
  output logic              vid_rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              cpu_wr_req,
  input  logic              ppu_wr_req,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [ADDR_W-1:0] ppu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic [DATA_W-1:0] ppu_wr_data,
  output logic              cpu_wr_gnt,
  output logic              ppu_wr_gnt,
  input  logic              cpu_lock,
  input  logic              ppu_lock,
  output logic [ADDR_W-1:0] mem_read_address,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMaxC = CntW'(STARVE_MAX);

  owner_e            state_q, state_d;
  tag_t              tag_q, tag_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic [ADDR_W-1:0] raddr_q;
  logic              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;

  logic arb_rd_cpu, arb_rd_ppu, arb_rd_tog;
  logic arb_wr_cpu, arb_wr_ppu, arb_wr_tog;
  logic idle;

  assign idle = (state_q == StIdle);

  // Video always wins the read port, so mask it out before the CPU/PPU pick.
  chip8_arb2 u_rd_arb (
    .cpu_req    (cpu_rd_req & ~vid_rd_req),
    .ppu_req    (ppu_rd_req & ~vid_rd_req),
    .force_cpu  (starve_q == StarveMaxC),
    .ptr        (rd_ptr_q),
    .cpu_gnt    (arb_rd_cpu),
    .ppu_gnt    (arb_rd_ppu),
    .ptr_toggle (arb_rd_tog)
  );

  chip8_arb2 u_wr_arb (
    .cpu_req    (cpu_wr_req),
    .ppu_req    (ppu_wr_req),
    .force_cpu  (1'b0),
    .ptr        (wr_ptr_q),
    .cpu_gnt    (arb_wr_cpu),
    .ppu_gnt    (arb_wr_ppu),
    .ptr_toggle (arb_wr_tog)
  );

  always_comb begin
    vid_rd_gnt = vid_rd_req;
    cpu_rd_gnt = 1'b0;
    ppu_rd_gnt = 1'b0;
    cpu_wr_gnt = 1'b0;
    ppu_wr_gnt = 1'b0;
    unique case (state_q)
      StCpuLock: begin
        cpu_rd_gnt = cpu_rd_req & ~vid_rd_req;
        cpu_wr_gnt = cpu_wr_req;
      end
      StPpuLock: begin
        ppu_rd_gnt = ppu_rd_req & ~vid_rd_req;
        ppu_wr_gnt = ppu_wr_req;
      end
      default: begin
        cpu_rd_gnt = arb_rd_cpu;
        ppu_rd_gnt = arb_rd_ppu;
        cpu_wr_gnt = arb_wr_cpu;
        ppu_wr_gnt = arb_wr_ppu;
      end
    endcase
  end

  assign rd_ptr_d = rd_ptr_q ^ (arb_rd_tog & idle);
  assign wr_ptr_d = wr_ptr_q ^ (arb_wr_tog & idle);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCpuLock: if (!cpu_lock) state_d = StIdle;
      StPpuLock: if (!ppu_lock) state_d = StIdle;
      default: begin
        if (ppu_lock && (ppu_rd_gnt || ppu_wr_gnt)) begin
          state_d = StPpuLock;
        end else if (cpu_lock && (cpu_rd_gnt || cpu_wr_gnt)) begin
          state_d = StCpuLock;
        end
      end
    endcase
  end

  always_comb begin
    tag_d            = TagNone;
    mem_read_address = raddr_q;
    if (vid_rd_gnt) begin
      tag_d            = TagVid;
      mem_read_address = vid_rd_addr;
    end else if (cpu_rd_gnt) begin
      tag_d            = TagCpu;
      mem_read_address = cpu_rd_addr;
    end else if (ppu_rd_gnt) begin
      tag_d            = TagPpu;
      mem_read_address = ppu_rd_addr;
    end
  end

  always_comb begin
    mem_write_address = '0;
    mem_write_data    = '0;
    if (cpu_wr_gnt) begin
      mem_write_address = cpu_wr_addr;
      mem_write_data    = cpu_wr_data;
    end else if (ppu_wr_gnt) begin
      mem_write_address = ppu_wr_addr;
      mem_write_data    = ppu_wr_data;
    end
  end

  assign mem_write_enable = cpu_wr_gnt | ppu_wr_gnt;

  // A PPU lock pauses the starvation count rather than clearing it.
  always_comb begin
    starve_d = starve_q;
    if (!cpu_rd_req || cpu_rd_gnt) begin
      starve_d = '0;
    end else if (state_q != StPpuLock && starve_q != StarveMaxC) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      tag_q    <= TagNone;
      starve_q <= '0;
      raddr_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      starve_q <= starve_d;
      raddr_q  <= mem_read_address;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign cpu_rd_valid = (tag_q == TagCpu);
  assign ppu_rd_valid = (tag_q == TagPpu);
  assign vid_rd_valid = (tag_q == TagVid);
  assign rd_data      = mem_read_data;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed self-checking bench for chip8_mem_arbiter with a registered-read RAM model.
module tb_chip8_mem_arbiter;
  import chip8_mem_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic          clk, reset;
  logic          cpu_rd_req, ppu_rd_req, vid_rd_req;
  logic [AW-1:0] cpu_rd_addr, ppu_rd_addr, vid_rd_addr;
  logic          cpu_rd_gnt, ppu_rd_gnt, vid_rd_gnt;
  logic          cpu_rd_valid, ppu_rd_valid, vid_rd_valid;
  logic [DW-1:0] rd_data;
  logic          cpu_wr_req, ppu_wr_req;
  logic [AW-1:0] cpu_wr_addr, ppu_wr_addr;
  logic [DW-1:0] cpu_wr_data, ppu_wr_data;
  logic          cpu_wr_gnt, ppu_wr_gnt;
  logic          cpu_lock, ppu_lock;
  logic [AW-1:0] mem_read_address, mem_write_address;
  logic [DW-1:0] mem_read_data, mem_write_data;
  logic          mem_write_enable;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  chip8_mem_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_rd_req        (cpu_rd_req),
    .ppu_rd_req        (ppu_rd_req),
    .vid_rd_req        (vid_rd_req),
    .cpu_rd_addr       (cpu_rd_addr),
    .ppu_rd_addr       (ppu_rd_addr),
    .vid_rd_addr       (vid_rd_addr),
    .cpu_rd_gnt        (cpu_rd_gnt),
    .ppu_rd_gnt        (ppu_rd_gnt),
    .vid_rd_gnt        (vid_rd_gnt),
    .cpu_rd_valid      (cpu_rd_valid),
    .ppu_rd_valid      (ppu_rd_valid),
    .vid_rd_valid      (vid_rd_valid),
    .rd_data           (rd_data),
    .cpu_wr_req        (cpu_wr_req),
    .ppu_wr_req        (ppu_wr_req),
    .cpu_wr_addr       (cpu_wr_addr),
    .ppu_wr_addr       (ppu_wr_addr),
    .cpu_wr_data       (cpu_wr_data),
    .ppu_wr_data       (ppu_wr_data),
    .cpu_wr_gnt        (cpu_wr_gnt),
    .ppu_wr_gnt        (ppu_wr_gnt),
    .cpu_lock          (cpu_lock),
    .ppu_lock          (ppu_lock),
    .mem_read_address  (mem_read_address),
    .mem_read_data     (mem_read_data),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_write_enable  (mem_write_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_read_data <= ram[mem_read_address];
    if (mem_write_enable) ram[mem_write_address] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int seen;
  int gnt_at;
  logic exp_ppu;

  initial begin
    for (int a = 0; a < (1 << AW); a++) ram[a] = '0;
    ram[12'hF00] = 8'hA5;
    ram[12'h22A] = 8'h3C;
    ram[12'h200] = 8'h7E;
    mem_read_data = '0;
    reset = 1'b0;
    {cpu_rd_req, ppu_rd_req, vid_rd_req, cpu_wr_req, ppu_wr_req, cpu_lock, ppu_lock} = '0;
    {cpu_rd_addr, ppu_rd_addr, vid_rd_addr, cpu_wr_addr, ppu_wr_addr} = '0;
    {cpu_wr_data, ppu_wr_data} = '0;

    // Reset
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_gnts", {cpu_rd_gnt, ppu_rd_gnt, vid_rd_gnt, cpu_wr_gnt, ppu_wr_gnt}, 0);
    check("rst_valids", {cpu_rd_valid, ppu_rd_valid, vid_rd_valid}, 0);
    check("rst_we", mem_write_enable, 0);
    check("rst_raddr", mem_read_address, 0);
    check("rst_waddr", mem_write_address, 0);
    check("rst_state", dut.state_q, StIdle);

    // Read conflict: video, then PPU, then CPU
    step();
    {vid_rd_req, ppu_rd_req, cpu_rd_req} = 3'b111;
    vid_rd_addr = 12'hF00;
    ppu_rd_addr = 12'h22A;
    cpu_rd_addr = 12'h200;
    @(negedge clk);
    check("rc_gnt_vid", {vid_rd_gnt, ppu_rd_gnt, cpu_rd_gnt}, 3'b100);
    check("rc_addr_vid", mem_read_address, 12'hF00);
    step();
    vid_rd_req = 1'b0;
    check("rc_valid_vid", {vid_rd_valid, ppu_rd_valid, cpu_rd_valid}, 3'b100);
    check("rc_data_vid", rd_data, 8'hA5);
    @(negedge clk);
    check("rc_gnt_ppu", {vid_rd_gnt, ppu_rd_gnt, cpu_rd_gnt}, 3'b010);
    check("rc_addr_ppu", mem_read_address, 12'h22A);
    step();
    ppu_rd_req = 1'b0;
    check("rc_valid_ppu", {vid_rd_valid, ppu_rd_valid, cpu_rd_valid}, 3'b010);
    check("rc_data_ppu", rd_data, 8'h3C);
    @(negedge clk);
    check("rc_gnt_cpu", {vid_rd_gnt, ppu_rd_gnt, cpu_rd_gnt}, 3'b001);
    check("rc_addr_cpu", mem_read_address, 12'h200);
    step();
    cpu_rd_req = 1'b0;
    check("rc_valid_cpu", {vid_rd_valid, ppu_rd_valid, cpu_rd_valid}, 3'b001);
    check("rc_data_cpu", rd_data, 8'h7E);
    @(negedge clk);
    check("rc_addr_hold", mem_read_address, 12'h200);

    // PPU lock held for 15 cycles while the CPU wants to write 0x300
    step();
    ppu_lock    = 1'b1;
    ppu_rd_req  = 1'b1;
    ppu_rd_addr = 12'h010;
    @(negedge clk);
    check("lk_acq_gnt", ppu_rd_gnt, 1);
    step();
    ppu_rd_req  = 1'b0;
    cpu_wr_req  = 1'b1;
    cpu_wr_addr = 12'h300;
    cpu_wr_data = 8'h5A;
    cpu_rd_req  = 1'b1;
    cpu_rd_addr = 12'h200;
    check("lk_state", dut.state_q, StPpuLock);
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      vid_rd_req  = (i == 5);
      vid_rd_addr = 12'hF00;
      @(negedge clk);
      if (cpu_wr_gnt || cpu_rd_gnt) seen++;
      if (i == 5) check("lk_vid_gnt", vid_rd_gnt, 1);
      step();
    end
    ppu_lock = 1'b0;
    @(negedge clk);
    if (cpu_wr_gnt || cpu_rd_gnt) seen++;
    check("lk_cpu_blocked", seen, 0);
    check("lk_starve_hold", dut.starve_q, 0);
    step();
    @(negedge clk);
    check("lk_rel_wgnt", cpu_wr_gnt, 1);
    check("lk_rel_we", mem_write_enable, 1);
    check("lk_rel_waddr", mem_write_address, 12'h300);
    check("lk_ram_old", ram[12'h300], 8'h00);
    step();
    cpu_wr_req = 1'b0;
    cpu_rd_req = 1'b0;
    check("lk_ram_new", ram[12'h300], 8'h5A);
    check("lk_state_idle", dut.state_q, StIdle);

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Starvation: PPU reads every cycle, CPU forced after 15 denials
    ppu_rd_req  = 1'b1;
    cpu_rd_req  = 1'b1;
    ppu_rd_addr = 12'h22A;
    cpu_rd_addr = 12'h200;
    gnt_at = -1;
    for (int i = 0; i < 20 && gnt_at < 0; i++) begin
      @(negedge clk);
      if (cpu_rd_gnt) gnt_at = i;
      else step();
    end
    check("sv_gnt_cycle", gnt_at, 15);
    check("sv_cnt_max", dut.starve_q, 15);
    step();
    check("sv_cnt_clear", dut.starve_q, 0);
    check("sv_cpu_valid", cpu_rd_valid, 1);
    check("sv_cpu_data", rd_data, 8'h7E);
    cpu_rd_req = 1'b0;
    ppu_rd_req = 1'b0;
`endif

    // Contested writes: alternate with round-robin, PPU always otherwise
    cpu_wr_req  = 1'b1;
    ppu_wr_req  = 1'b1;
    cpu_wr_addr = 12'h400;
    ppu_wr_addr = 12'h401;
    cpu_wr_data = 8'h11;
    ppu_wr_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_ppu = ((i % 2) == 0);
`else
      exp_ppu = 1'b1;
`endif
      @(negedge clk);
      check("wr_ppu_gnt", ppu_wr_gnt, exp_ppu);
      check("wr_cpu_gnt", cpu_wr_gnt, !exp_ppu);
      step();
    end
    cpu_wr_req = 1'b0;
    ppu_wr_req = 1'b0;

    // Reset asserted in the grant cycle of a locking PPU read
    ppu_rd_req  = 1'b1;
    ppu_lock    = 1'b1;
    ppu_rd_addr = 12'h055;
    @(negedge clk);
    check("mr_gnt", ppu_rd_gnt, 1);
    #2 reset = 1'b0;
    seen = 0;
    step();
    ppu_rd_req = 1'b0;
    ppu_lock   = 1'b0;
    if (ppu_rd_valid) seen++;
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ppu_rd_valid) seen++;
      step();
    end
    check("mr_no_valid", seen, 0);
    check("mr_state", dut.state_q, StIdle);
    check("mr_starve", dut.starve_q, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_mem_arbiter.md
# chip8_mem_arbiter

Shares the single-read/single-write-port CHIP-8 RAM between the CPU, the PPU, and the video scanout reader. Arbitrates each port every cycle and tags read returns so each requester knows when data on the shared read bus is its own. Provides an optional lock so a multi-cycle PPU sprite draw runs atomically against CPU writes. Sits between the three masters and `chip8_ram`, driving its `read_address`, `write_address`, `d` and `we`.

## Interface
- `ADDR_W`, default 12: RAM address width.
- `DATA_W`, default 8: RAM data width.
- `STARVE_MAX`, default 15: number of consecutive denied CPU read cycles before the CPU read is forced.

- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `cpu_rd_req`, `ppu_rd_req`, `vid_rd_req`  in  1 each: read requests.
- `cpu_rd_addr`, `ppu_rd_addr`, `vid_rd_addr`  in  ADDR_W each: read addresses.
- `cpu_rd_gnt`, `ppu_rd_gnt`, `vid_rd_gnt`  out  1 each: read accepted this cycle.
- `cpu_rd_valid`, `ppu_rd_valid`, `vid_rd_valid`  out  1 each: `rd_data` holds this requester's data.
- `rd_data`  out  DATA_W: broadcast of `mem_read_data`.
- `cpu_wr_req`, `ppu_wr_req`  in  1 each: write requests.
- `cpu_wr_addr`, `ppu_wr_addr`  in  ADDR_W each: write addresses.
- `cpu_wr_data`, `ppu_wr_data`  in  DATA_W each: write data.
- `cpu_wr_gnt`, `ppu_wr_gnt`  out  1 each: write performed at the next edge.
- `cpu_lock`, `ppu_lock`  in  1 each: request or hold exclusive ownership.
- `mem_read_address`  out  ADDR_W: to the RAM read port.
- `mem_read_data`  in  DATA_W: registered RAM read data.
- `mem_write_address`  out  ADDR_W: to the RAM write port.
- `mem_write_data`  out  DATA_W: to the RAM write port.
- `mem_write_enable`  out  1: RAM write enable.

## Operation
- **Owner FSM:** states IDLE, CPU_LOCK, PPU_LOCK.
  - IDLE → X_LOCK when X asserts `x_lock` and wins any grant that cycle. If both assert lock, the arbitration winner takes the lock.
  - X_LOCK → IDLE when `x_lock` is sampled low.
- **Read port priority:**
  1. Video has highest priority and is never blocked, including under a lock.
  2. Next is the lock owner; the non-owner's read is blocked while locked.
  3. In IDLE: CPU if its starvation counter equals STARVE_MAX, else PPU over CPU (see Configuration).
- **Write port:**
  - Under a lock, only the owner may write.
  - In IDLE, PPU wins over CPU (see Configuration).
- **Grant behaviour:**
  - Grants are combinational from the current requests and state. At most one read grant and one write grant are high per cycle.
  - With no read grant, `mem_read_address` holds its last value.
  - `mem_write_enable` equals the OR of the write grants.
- **Read tagging:** a 2-bit owner tag is registered on every read grant. `x_rd_valid` is high exactly one cycle after `x_rd_gnt`.
- **Starvation counter:**
  - Width is that of STARVE_MAX.
  - Increments while `cpu_rd_req` is high, `cpu_rd_gnt` is low, and the state is not PPU_LOCK.
  - Clears on a CPU read grant or when `cpu_rd_req` is low.
  - Saturates at STARVE_MAX.
- **No read-during-write forwarding:** a same-address read and write in one cycle returns the old RAM contents.

## Timing
- **Reset values:**
  - All grants and all valids 0.
  - `mem_write_enable` 0; `mem_read_address`, `mem_write_address`, `mem_write_data` 0.
  - FSM in IDLE; starvation counter 0; round-robin pointer favours PPU.
- **Read latency:** address is presented in grant cycle N; `rd_data` and `x_rd_valid` are valid in cycle N+1. Back-to-back reads from one requester run at one per cycle.
- **Write:** committed at the edge ending the grant cycle.
- **Handshake:** a requester holds `req` and its address/data stable until it sees `gnt`. The arbiter never drops a grant without a request.
- **Lock behaviour:**
  - The lock takes effect from the cycle after acquisition.
  - The owner keeps exclusivity even while its `req` is low.
  - On release, the next cycle is arbitrated as IDLE.
- **Reset mid-operation:** pending valids are cleared, the lock is dropped, and the counter is cleared. A read granted in the cycle reset asserts gets no valid.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`:
  - Defined: CPU/PPU conflicts in IDLE on both ports alternate through a 1-bit pointer per port. The pointer toggles after each contested grant.
  - Undefined: fixed PPU-over-CPU priority.
- Video priority, locking and starvation forcing are identical either way.

## Structure
- Shared package `chip8_mem_pkg`:
  - Owner-state encoding: IDLE/CPU_LOCK/PPU_LOCK.
  - Requester tag constants: TAG_NONE/CPU/PPU/VID.
  - Default ADDR_W/DATA_W.
- Sub-module `chip8_arb2`:
  - Two-way picker for CPU vs PPU.
  - Inputs: two requests, a force-CPU input, and the pointer.
  - Outputs: two one-hot grants and the pointer update.
  - Instantiated once for the read port and once for the write port.

## Test plan
- **Reset:** after reset release with all requests low, all grants, valids and `mem_write_enable` are 0.
- **Read conflict:** `vid_rd_req`, `ppu_rd_req` and `cpu_rd_req` are asserted together with addresses 0xF00/0x22A/0x200. Expect `vid_rd_gnt` first, then PPU, then CPU. Each `x_rd_valid` follows its grant by one cycle, carrying RAM contents preloaded at those addresses.
- **PPU lock:** `ppu_lock` is held for 15 cycles while the CPU requests a write to 0x300. Expect `cpu_wr_gnt` low for the whole lock, high in the first cycle after release, and RAM[0x300] updated one edge later.
- **Starvation:** PPU reads requested every cycle, CPU read requested, macro undefined. Expect `cpu_rd_gnt` high on the cycle the counter reaches 15, then the counter returns to 0.
- **Round-robin:** with `MEM_ARB_ROUND_ROBIN_EN` defined, CPU and PPU write continuously. Grants alternate PPU, CPU, PPU, CPU on successive cycles.
- **Reset mid-read:** `reset` is asserted low in the grant cycle of a PPU read. `ppu_rd_valid` never asserts, and the FSM is IDLE after release.
